// File: rtl/pa_gemm_tile.sv
// ROWS x COLS outer-product MAC tile: accumulates C += a*b^T over K input beats,
// then streams the accumulator rows out one per beat under consumer back-pressure.
module pa_gemm_tile #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int WIDTH_DATA = 16,
   parameter int WIDTH_ACC  = 40,
   parameter int WIDTH_K    = 8,
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic [WIDTH_K-1:0]         k_len_i,
   input  logic                       acc_mode_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [ROWS*WIDTH_DATA-1:0] a_bus_i,
   input  logic [COLS*WIDTH_DATA-1:0] b_bus_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [ROW_W-1:0]           out_row_o,
   output logic [COLS*WIDTH_ACC-1:0]  out_data_o,
   output logic                       busy_o,
   output logic                       done_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                        r_state;
   state_t                        w_nextState;
   logic [WIDTH_K-1:0]            r_kLen;
   logic [WIDTH_K-1:0]            r_beatCnt;
   logic [WIDTH_K:0]              w_cntNext;
   logic                          w_lastBeat;
   logic [ROW_W-1:0]              r_outRow;
   logic                          w_lastRow;
   logic                          r_done;
   logic signed [WIDTH_ACC-1:0]   r_acc  [ROWS][COLS];
   logic signed [WIDTH_DATA-1:0]  w_a    [ROWS];
   logic signed [WIDTH_DATA-1:0]  w_b    [COLS];
   logic signed [2*WIDTH_DATA-1:0] w_prod [ROWS][COLS];

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_aSlice
      assign w_a[gr] = a_bus_i[gr*WIDTH_DATA +: WIDTH_DATA];
   end
   for (genvar gc = 0; gc < COLS; gc++) begin : g_bSlice
      assign w_b[gc] = b_bus_i[gc*WIDTH_DATA +: WIDTH_DATA];
   end
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_prodRow
      for (genvar gc = 0; gc < COLS; gc++) begin : g_prodCol
         assign w_prod[gr][gc] = w_a[gr] * w_b[gc];
      end
   end

   // One extra bit so the compare cannot overflow when K is at its maximum.
   assign w_cntNext  = {1'b0, r_beatCnt} + (WIDTH_K+1)'(1);
   assign w_lastBeat = (w_cntNext == {1'b0, r_kLen});
   assign w_lastRow  = (r_outRow == ROW_W'(ROWS - 1));

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_nextState = (k_len_i == '0) ? S_DRAIN : S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid_i && w_lastBeat) begin
               w_nextState = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_ready_i && w_lastRow) begin
               w_nextState = S_IDLE;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_kLen    <= '0;
         r_beatCnt <= '0;
         r_outRow  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_kLen    <= k_len_i;
                  r_beatCnt <= '0;
               end
            end
            S_LOAD: begin
               if (in_valid_i) begin
                  r_beatCnt <= w_cntNext[WIDTH_K-1:0];
               end
            end
            S_DRAIN: begin
               if (out_ready_i) begin
                  if (w_lastRow) begin
                     r_outRow <= '0;
                     r_done   <= 1'b1;
                  end else begin
                     r_outRow <= r_outRow + ROW_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Accumulators survive IDLE so a job with acc_mode_i=1 can continue a long K.
   always_ff @(posedge clk) begin
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (!rst_n) begin
               r_acc[r][c] <= '0;
            end else if (r_state == S_IDLE && start_i && !acc_mode_i) begin
               r_acc[r][c] <= '0;
            end else if (r_state == S_LOAD && in_valid_i) begin
               r_acc[r][c] <= r_acc[r][c] + WIDTH_ACC'(w_prod[r][c]);
            end
         end
      end
   end

   always_comb begin
      out_data_o = '0;
      for (int c = 0; c < COLS; c++) begin
         out_data_o[c*WIDTH_ACC +: WIDTH_ACC] = r_acc[r_outRow][c];
      end
   end

   assign in_ready_o  = (r_state == S_LOAD);
   assign out_valid_o = (r_state == S_DRAIN);
   assign busy_o      = (r_state != S_IDLE);
   assign out_row_o   = r_outRow;
   assign done_o      = r_done;

endmodule

// File: tb/tb_pa_gemm_tile.sv
// Randomized self-checking bench for pa_gemm_tile against a plain-arithmetic matrix model.
module tb_pa_gemm_tile;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int WD   = 16;
   localparam int WA   = 32;
   localparam int WK   = 8;
   localparam int RW   = 2;

   logic                 clk;
   logic                 rst_n;
   logic                 start_i;
   logic [WK-1:0]        k_len_i;
   logic                 acc_mode_i;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [ROWS*WD-1:0]   a_bus_i;
   logic [COLS*WD-1:0]   b_bus_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [RW-1:0]        out_row_o;
   logic [COLS*WA-1:0]   out_data_o;
   logic                 busy_o;
   logic                 done_o;

   int checkCount;
   int errorCount;

   logic signed [WD-1:0] aBeat [256][ROWS];
   logic signed [WD-1:0] bBeat [256][COLS];
   longint               modelAcc [ROWS][COLS];

   pa_gemm_tile #(
      .ROWS(ROWS), .COLS(COLS), .WIDTH_DATA(WD), .WIDTH_ACC(WA), .WIDTH_K(WK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
      .acc_mode_i(acc_mode_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .a_bus_i(a_bus_i), .b_bus_i(b_bus_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_row_o(out_row_o), .out_data_o(out_data_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearModel();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            modelAcc[r][c] = 0;
   endtask

   task automatic checkRow(input int r);
      logic [WA-1:0] expVal;
      checkOutput("out_valid in drain", 64'(out_valid_o), 64'(1));
      checkOutput("out_row", 64'(out_row_o), 64'(r));
      checkOutput("done low in drain", 64'(done_o), 64'(0));
      for (int c = 0; c < COLS; c++) begin
         expVal = modelAcc[r][c][WA-1:0];
         checkOutput($sformatf("data r%0d c%0d", r, c), 64'(out_data_o[c*WA +: WA]), 64'(expVal));
      end
   endtask

   // One job: start, feed K beats from aBeat/bBeat, drain (optional stall or reset).
   task automatic applyStimulus(input int k, input bit mode, input bit randValid,
                                input bit stallRow1, input int resetAtRow);
      int  idx;
      int  guard;
      bit  accepted;
      start_i    = 1'b1;
      k_len_i    = k[WK-1:0];
      acc_mode_i = mode;
      stepCycle();
      start_i = 1'b0;
      if (!mode) clearModel();
      checkOutput("busy after start", 64'(busy_o), 64'(1));
      checkOutput("in_ready after start", 64'(in_ready_o), 64'(k != 0));
      idx   = 0;
      guard = 0;
      while (idx < k && guard < 4000) begin
         in_valid_i = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int r = 0; r < ROWS; r++)
            a_bus_i[r*WD +: WD] = in_valid_i ? aBeat[idx][r] : WD'($urandom);
         for (int c = 0; c < COLS; c++)
            b_bus_i[c*WD +: WD] = in_valid_i ? bBeat[idx][c] : WD'($urandom);
         start_i    = randValid ? 1'($urandom_range(0, 1)) : 1'b0;
         k_len_i    = WK'($urandom);
         acc_mode_i = 1'b0;
         accepted   = in_valid_i && in_ready_o;
         stepCycle();
         if (accepted) begin
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++)
                  modelAcc[r][c] += longint'(aBeat[idx][r]) * longint'(bBeat[idx][c]);
            idx++;
         end
         guard++;
      end
      in_valid_i = 1'b0;
      start_i    = 1'b0;
      checkOutput("beats accepted", 64'(idx), 64'(k));
      checkOutput("out_valid after load", 64'(out_valid_o), 64'(1));
      checkOutput("in_ready off in drain", 64'(in_ready_o), 64'(0));
      for (int r = 0; r < ROWS; r++) begin
         checkRow(r);
         if (r == resetAtRow) begin
            rst_n       = 1'b0;
            out_ready_i = 1'b1;
            stepCycle();
            rst_n       = 1'b1;
            out_ready_i = 1'b0;
            clearModel();
            checkOutput("rst out_valid", 64'(out_valid_o), 64'(0));
            checkOutput("rst in_ready", 64'(in_ready_o), 64'(0));
            checkOutput("rst busy", 64'(busy_o), 64'(0));
            checkOutput("rst done", 64'(done_o), 64'(0));
            checkOutput("rst out_row", 64'(out_row_o), 64'(0));
            checkOutput("rst out_data", 64'(out_data_o), 64'(0));
            return;
         end
         if (stallRow1 && r == 1) begin
            out_ready_i = 1'b0;
            repeat (3) begin
               start_i    = 1'b1;
               k_len_i    = '0;
               acc_mode_i = 1'b0;
               stepCycle();
               checkRow(r);
            end
            start_i = 1'b0;
         end
         out_ready_i = 1'b1;
         stepCycle();
      end
      out_ready_i = 1'b0;
      checkOutput("done pulse", 64'(done_o), 64'(1));
      checkOutput("busy after drain", 64'(busy_o), 64'(0));
      checkOutput("out_valid after drain", 64'(out_valid_o), 64'(0));
      stepCycle();
      checkOutput("done one cycle", 64'(done_o), 64'(0));
   endtask

   task automatic fillConst(input int k, input int aVal, input int bVal);
      for (int i = 0; i < k; i++) begin
         for (int r = 0; r < ROWS; r++) aBeat[i][r] = WD'(aVal);
         for (int c = 0; c < COLS; c++) bBeat[i][c] = WD'(bVal);
      end
   endtask

   task automatic fillRandom(input int k);
      for (int i = 0; i < k; i++) begin
         for (int r = 0; r < ROWS; r++) aBeat[i][r] = WD'($urandom);
         for (int c = 0; c < COLS; c++) bBeat[i][c] = WD'($urandom);
      end
   endtask

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      rst_n       = 1'b0;
      start_i     = 1'b0;
      k_len_i     = '0;
      acc_mode_i  = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      a_bus_i     = '0;
      b_bus_i     = '0;
      clearModel();
      repeat (2) stepCycle();
      checkOutput("reset in_ready", 64'(in_ready_o), 64'(0));
      checkOutput("reset out_valid", 64'(out_valid_o), 64'(0));
      checkOutput("reset busy", 64'(busy_o), 64'(0));
      checkOutput("reset done", 64'(done_o), 64'(0));
      checkOutput("reset out_row", 64'(out_row_o), 64'(0));
      checkOutput("reset out_data", 64'(out_data_o), 64'(0));
      rst_n = 1'b1;
      stepCycle();

      $display("[TB] identity job");
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < ROWS; r++) aBeat[i][r] = (r == i) ? WD'(1) : WD'(0);
         for (int c = 0; c < COLS; c++) bBeat[i][c] = WD'(1 + c + 4*i);
      end
      applyStimulus(4, 1'b0, 1'b0, 1'b0, -1);

      $display("[TB] accumulate mode");
      fillConst(2, 3, 5);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, -1);
      fillConst(1, 1, -40);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, -1);

      $display("[TB] signed extremes");
      fillConst(2, -32768, -32768);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, -1);

      $display("[TB] handshake stalls");
      fillRandom(7);
      applyStimulus(7, 1'b0, 1'b1, 1'b1, -1);

      $display("[TB] zero length");
      applyStimulus(0, 1'b0, 1'b0, 1'b0, -1);

      $display("[TB] random jobs");
      for (int j = 0; j < 6; j++) begin
         int k;
         k = $urandom_range(1, 6);
         fillRandom(k);
         applyStimulus(k, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), -1);
      end

      $display("[TB] reset mid-drain");
      fillRandom(3);
      applyStimulus(3, 1'b0, 1'b0, 1'b0, 2);
      fillConst(1, 2, 2);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pa_gemm_tile.md
# pa_gemm_tile

Parametrised ROWS x COLS multiply-accumulate tile that computes an outer-product accumulation C += A·B over a programmable inner length K. It takes one column of A and one row of B per beat over a valid/ready input stream. When the K beats are done, it drains the C rows one per beat over a valid/ready output stream. It is the next-generation processor array. Compared with the fixed square array with its free-running sequencer, it adds:
- rectangular geometry
- runtime K
- clear/accumulate modes
- back-pressured result readout

## Interface
Parameters:
- ROWS, 4, number of accumulator rows (A elements per beat)
- COLS, 4, number of accumulator columns (B elements per beat)
- WIDTH_DATA, 16, signed operand width
- WIDTH_ACC, 40, signed accumulator width; must be ≥ 2*WIDTH_DATA
- WIDTH_K, 8, width of the K-length field

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  starts a job; sampled only in IDLE
- k_len_i  in  WIDTH_K  number of input beats for the job; latched on start
- acc_mode_i  in  1  0 = clear accumulators at start, 1 = accumulate onto existing values; latched on start
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  tile accepts an input beat
- a_bus_i  in  ROWS*WIDTH_DATA  A column; a[r] = a_bus_i[r*WIDTH_DATA +: WIDTH_DATA]
- b_bus_i  in  COLS*WIDTH_DATA  B row; b[c] = b_bus_i[c*WIDTH_DATA +: WIDTH_DATA]
- out_valid_o  out  1  result row valid
- out_ready_i  in  1  consumer accepts a result row
- out_row_o  out  $clog2(ROWS) (min 1)  index of the row on out_data_o
- out_data_o  out  COLS*WIDTH_ACC  acc[out_row_o][c] at slice c*WIDTH_ACC
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when a job completes

## Operation
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - in_ready_o=0, out_valid_o=0.
  - start_i=1 latches k_len_i and acc_mode_i and clears the beat counter.
  - If acc_mode_i=0, all ROWS*COLS accumulators are zeroed on that same edge.
  - Next state is LOAD, or DRAIN directly if k_len_i=0.
- LOAD:
  - in_ready_o=1.
  - Each handshake (in_valid_i & in_ready_o) updates every accumulator: acc[r][c] += a[r]*b[c].
  - The beat counter increments on each handshake.
  - The handshake that makes the count equal K moves the FSM to DRAIN.
  - Cycles with in_valid_i=0 are stalls: no change.
- DRAIN:
  - out_valid_o=1; out_row_o starts at 0.
  - out_data_o is a combinational view of the accumulator row selected by out_row_o.
  - Each handshake (out_valid_o & out_ready_i) increments out_row_o.
  - The handshake on row ROWS-1 returns the FSM to IDLE, resets out_row_o to 0 and pulses done_o.
  - out_data_o and out_row_o stay stable while out_valid_o=1 and out_ready_i=0.
- Accumulators keep their values in IDLE. acc_mode_i=1 on the next start continues from them, which allows K>2^WIDTH_K-1 to be split across jobs.
- Arithmetic:
  - Operands are signed two's complement; the product is 2*WIDTH_DATA bits.
  - The product is sign-extended to WIDTH_ACC.
  - The sum wraps modulo 2^WIDTH_ACC, with no saturation.
- start_i outside IDLE is ignored. k_len_i and acc_mode_i are ignored outside the start cycle.
- rst_n=0 in any state, mid-LOAD or mid-DRAIN, forces on the next edge:
  - state IDLE
  - all accumulators 0
  - beat counter 0, out_row_o 0
  - done_o 0
  
  An in-flight job is discarded.

## Timing
- Reset values: in_ready_o 0, out_valid_o 0, busy_o 0, done_o 0, out_row_o 0, out_data_o 0 (all accumulators 0).
- With start_i at edge T:
  - busy_o and in_ready_o go high in cycle T+1.
  - With in_valid_i held high, beats are accepted in cycles T+1 .. T+K.
  - out_valid_o goes high in cycle T+K+1.
- Accumulator update is single-cycle. A row accepted in LOAD at edge t is visible in acc from t+1.
- Drain with out_ready_i held high: rows 0..ROWS-1 appear in cycles T+K+1 .. T+K+ROWS.
  - done_o=1 and busy_o=0 in cycle T+K+ROWS+1.
  - A new start_i is accepted in that same cycle.
- With k_len_i=0, out_valid_o goes high in cycle T+1.
- in_ready_o and out_valid_o are decoded from registered state only. There is no combinational path from in_valid_i or out_ready_i to any output.

## Test plan
- Identity clear job (ROWS=COLS=4, K=4):
  - Stimulus: beat k with a=e_k, b=row k of B = [1,2,3,4]+4k; out_ready_i=1.
  - Required: rows drain as B exactly; out_valid_o in cycle T+5; done_o in cycle T+9.
- Accumulate mode:
  - Stimulus: job 1 K=2 with a=all 3, b=all 5 (acc=30); job 2 acc_mode_i=1, K=1, a=all 1, b=all -40.
  - Required: every result = -10.
- Signed extremes and wrap (WIDTH_DATA=16, WIDTH_ACC=32, K=2):
  - Stimulus: a=-32768, b=-32768 twice.
  - Required: 2^31 wraps to -2147483648 in every element.
- Handshake stalls:
  - Stimulus: in_valid_i random 50%; out_ready_i low for 3 cycles on row 1.
  - Required: results identical to the no-stall golden; out_row_o/out_data_o stable while stalled; ignored start_i mid-job has no effect.
- k_len_i=0 with acc_mode_i=0:
  - Required: DRAIN in cycle T+1 with all-zero rows.
- Reset mid-DRAIN:
  - Stimulus: rst_n=0 on row 2.
  - Required: all outputs at reset values next cycle; following acc_mode_i=1, K=1 job with a=b=all 2 yields 4 everywhere.
